// File: rtl/prio_enc_pkg.sv
// Shared types and helpers for the latched priority encoder and its combinational core.
package prio_enc_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Index 0 is reserved for "no line", so lines 1..n need room for n+1 codes.
  function automatic int code_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int CODE_NONE = 0;

endpackage

// File: rtl/prio_enc_n.sv
// Generalised 74147 priority encoder: index of the highest set line (1..N_IN), 0 if none.
module prio_enc_n
  import prio_enc_pkg::*;
#(
  parameter int N_IN = 9,
  localparam int CODE_W = code_width(N_IN)
) (
  input  logic [N_IN:1]     eligible_i,
  output logic [CODE_W-1:0] idx_o,
  output logic              any_o
);

  // Ascending scan: the last hit is the highest-numbered line.
  always_comb begin
    idx_o = CODE_W'(CODE_NONE);
    for (int i = 1; i <= N_IN; i++) begin
      if (eligible_i[i]) begin
        idx_o = CODE_W'(i);
      end
    end
  end

  assign any_o = |eligible_i;

endmodule

// File: rtl/prio_encoder_latched.sv
// Registered priority encoder: sticky pending capture, mask, and a valid/ack grant handshake.
module prio_encoder_latched
  import prio_enc_pkg::*;
#(
  parameter int N_IN       = 9,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit EDGE_MODE  = 1'b0,
  localparam int CODE_W    = code_width(N_IN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_IN:1]     req,
  input  logic              mask_we,
  input  logic [N_IN:1]     mask_in,
  input  logic              ack,
  output logic [CODE_W-1:0] code,
  output logic [CODE_W-1:0] code_n,
  output logic              valid,
  output logic [N_IN:1]     pending
);

  logic [N_IN:1]     req_r_q, req_rr_q;
  logic [N_IN:1]     pend_q, pend_d;
  logic [N_IN:1]     mask_q, mask_d;
  logic [N_IN:1]     capture, eligible;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CODE_W-1:0] win_idx;
  logic              win_any;
  logic              valid_q, valid_d;
  logic              ack_take;
  state_e            state_q, state_d;

  assign capture  = EDGE_MODE ? (req_r_q & ~req_rr_q) : req_r_q;
  assign ack_take = (state_q == ST_GRANT) && ack;
  assign eligible = pend_q & ~mask_q;
  assign mask_d   = mask_we ? mask_in : mask_q;

  // Capture is OR-ed after the ack clear so a simultaneous new request is never lost.
  generate
    for (genvar gi = 1; gi <= N_IN; gi++) begin : g_pend
      assign pend_d[gi] = capture[gi] |
                          (pend_q[gi] & ~(ack_take && (code_q == CODE_W'(gi))));
    end
  endgenerate

  prio_enc_n #(.N_IN(N_IN)) u_enc (
    .eligible_i (eligible),
    .idx_o      (win_idx),
    .any_o      (win_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      req_r_q  <= '0;
      req_rr_q <= '0;
      pend_q   <= '0;
      mask_q   <= '0;
      state_q  <= ST_IDLE;
      code_q   <= CODE_W'(CODE_NONE);
      valid_q  <= 1'b0;
    end else begin
      req_r_q  <= ACTIVE_LOW ? ~req : req;
      req_rr_q <= req_r_q;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      state_q  <= state_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (win_any) state_d = ST_GRANT;
      ST_GRANT: if (ack)     state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  // Once granted, code/valid ignore requests and mask changes until the ack.
  always_comb begin
    code_d  = CODE_W'(CODE_NONE);
    valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_any) begin
          code_d  = win_idx;
          valid_d = 1'b1;
        end
      end
      ST_GRANT: begin
        if (!ack) begin
          code_d  = code_q;
          valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign code    = code_q;
  assign code_n  = ~code_q;
  assign valid   = valid_q;
  assign pending = pend_q;

endmodule

// File: tb/tb_prio_encoder_latched.sv
// Bench: level- and edge-mode instances share stimulus; each is checked every cycle against a line-level model.
module tb_prio_encoder_latched;

  localparam int N = 9;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N:1]   req = '0;
  logic         mask_we = 1'b0;
  logic [N:1]   mask_in = '0;
  logic         ack = 1'b0;

  logic [3:0]   lvl_code, lvl_code_n, edg_code, edg_code_n;
  logic         lvl_valid, edg_valid;
  logic [N:1]   lvl_pend, edg_pend;

  int n_cmp = 0;
  int n_mis = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  prio_encoder_latched #(.N_IN(N), .ACTIVE_LOW(1'b1), .EDGE_MODE(1'b0)) dut_lvl (
    .clk(clk), .rst(rst), .req(req), .mask_we(mask_we), .mask_in(mask_in), .ack(ack),
    .code(lvl_code), .code_n(lvl_code_n), .valid(lvl_valid), .pending(lvl_pend)
  );

  prio_encoder_latched #(.N_IN(N), .ACTIVE_LOW(1'b1), .EDGE_MODE(1'b1)) dut_edg (
    .clk(clk), .rst(rst), .req(req), .mask_we(mask_we), .mask_in(mask_in), .ack(ack),
    .code(edg_code), .code_n(edg_code_n), .valid(edg_valid), .pending(edg_pend)
  );

  // Behavioural model, index 0 = level capture, index 1 = edge capture.
  bit [N:1] m_rr[2], m_rprev[2], m_pend[2], m_mask[2];
  bit       m_valid[2];
  int       m_code[2];

  always @(posedge clk) begin
    bit [N:1] cap;
    int win;
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        m_rr[m] = '0; m_rprev[m] = '0; m_pend[m] = '0; m_mask[m] = '0;
        m_valid[m] = 1'b0; m_code[m] = 0;
      end else begin
        cap = (m == 1) ? (m_rr[m] & ~m_rprev[m]) : m_rr[m];
        win = 0;
        for (int i = 1; i <= N; i++)
          if (m_pend[m][i] && !m_mask[m][i]) win = i;
        if (m_valid[m]) begin
          if (ack) begin
            m_pend[m][m_code[m]] = 1'b0;
            m_valid[m] = 1'b0;
            m_code[m]  = 0;
          end
        end else if (win != 0) begin
          m_valid[m] = 1'b1;
          m_code[m]  = win;
        end
        m_pend[m]  = m_pend[m] | cap;
        if (mask_we) m_mask[m] = mask_in;
        m_rprev[m] = m_rr[m];
        m_rr[m]    = ~req;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_lvl", {lvl_valid, lvl_code, lvl_code_n, lvl_pend},
          {m_valid[0], 4'(m_code[0]), ~4'(m_code[0]), m_pend[0]});
      chk("model_edg", {edg_valid, edg_code, edg_code_n, edg_pend},
          {m_valid[1], 4'(m_code[1]), ~4'(m_code[1]), m_pend[1]});
    end
  end

  function automatic logic [N:1] ln(input int i);
    logic [N:1] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset with every line asserted (active low = 0).
    step(2);
    chk_en = 1'b1;
    chk("rst_valid_l", lvl_valid, 0);   chk("rst_code_l", lvl_code, 0);
    chk("rst_coden_l", lvl_code_n, 4'hF); chk("rst_pend_l", lvl_pend, 0);
    chk("rst_valid_e", edg_valid, 0);   chk("rst_pend_e", edg_pend, 0);
    rst = 1'b0;
    step(1); chk("fill_e0_pend", edg_pend, 0); chk("fill_e0_valid", edg_valid, 0);
    step(1); chk("fill_e1_pend", edg_pend, 9'h1FF); chk("fill_e1_valid", edg_valid, 0);
    step(1); chk("fill_e2_valid", edg_valid, 1); chk("fill_e2_code", edg_code, 9);
    chk("fill_e2_code_l", lvl_code, 9);
    $display("reset: fill and first grant 9 done");
    req = '1; rst = 1'b1; step(1); rst = 1'b0;

    // Priority between lines 3 and 7.
    req = ~(ln(3) | ln(7)); step(1); req = '1; step(2);
    chk("prio_code", edg_code, 7); chk("prio_coden", edg_code_n, 4'b1000); chk("prio_valid", edg_valid, 1);
    ack = 1'b1; step(1); ack = 1'b0;
    chk("prio_ack_valid", edg_valid, 0); chk("prio_ack_pend", edg_pend, ln(3));
    step(1); chk("prio_next_code", edg_code, 3); chk("prio_next_valid", edg_valid, 1);
    ack = 1'b1; step(1); chk("prio_ack2_valid", edg_valid, 0);
    step(1); chk("idle_ack_valid", edg_valid, 0); chk("idle_ack_pend", edg_pend, 0);
    ack = 1'b0;
    $display("priority: granted 7 then 3");

    // Mask excludes line 9 from arbitration but not from pending.
    mask_we = 1'b1; mask_in = ln(9); req = ~(ln(9) | ln(5)); step(1);
    mask_we = 1'b0; req = '1; step(2);
    chk("mask_code", edg_code, 5);
    ack = 1'b1; step(1); ack = 1'b0;
    chk("mask_pend", edg_pend, ln(9)); step(1); chk("mask_hold_valid", edg_valid, 0);
    mask_we = 1'b1; mask_in = '0; step(1); mask_we = 1'b0;
    step(1); chk("unmask_code", edg_code, 9); chk("unmask_valid", edg_valid, 1);
    ack = 1'b1; step(1); ack = 1'b0;
    $display("mask: granted 5, then 9 after unmask");

    // New edge on line 4 coincides with its ack.
    req = ~ln(4); step(1); req = '1; step(2);
    chk("coll_code", edg_code, 4);
    req = ~ln(4); step(1); req = '1; ack = 1'b1; step(1); ack = 1'b0;
    chk("coll_pend", edg_pend, ln(4)); chk("coll_valid", edg_valid, 0);
    step(1); chk("coll_regrant", edg_code, 4); chk("coll_regrant_v", edg_valid, 1);
    ack = 1'b1; step(1); ack = 1'b0;
    $display("collision: line 4 re-granted");

    // Level hold on line 8 is re-granted every two cycles.
    req = ~ln(8); step(3);
    chk("lvl_code", lvl_code, 8);
    for (int k = 0; k < 3; k++) begin
      ack = 1'b1; step(1); ack = 1'b0;
      chk("lvl_ack_valid", lvl_valid, 0); chk("lvl_ack_pend", lvl_pend, ln(8));
      step(1); chk("lvl_regrant", lvl_code, 8); chk("lvl_regrant_v", lvl_valid, 1);
    end
    req = '1; step(2);
    ack = 1'b1; step(1); ack = 1'b0;
    chk("lvl_rel_pend", lvl_pend, 0); chk("lvl_rel_valid", lvl_valid, 0);
    step(1); chk("lvl_rel_valid2", lvl_valid, 0);
    $display("level: line 8 re-granted 3 times, then released");

    // Reset while granting line 6.
    req = ~ln(6); step(1); req = '1; step(2);
    chk("midrst_code", edg_code, 6);
    rst = 1'b1; step(1); rst = 1'b0;
    chk("midrst_valid", edg_valid, 0); chk("midrst_code0", edg_code, 0);
    chk("midrst_coden", edg_code_n, 4'hF); chk("midrst_pend", edg_pend, 0);
    step(4); chk("midrst_quiet", edg_valid, 0); chk("midrst_quiet_l", lvl_valid, 0);
    $display("reset mid-grant: outputs cleared, no spurious grant");

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      req     = ~($urandom() & $urandom() & $urandom());
      ack     = 1'($urandom_range(0, 1));
      mask_we = ($urandom_range(0, 15) == 0);
      mask_in = N'($urandom());
      rst     = ($urandom_range(0, 255) == 0);
      step(1);
    end
    rst = 1'b0; ack = 1'b0; mask_we = 1'b0; req = '1;
    step(2);
    $display("random: 3000 cycles of mixed traffic done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
